ir_packet_encoder: RTL and testbench
====================================

// Module: ir_packet_encoder
// PURPOSE
//  Serialises one 4-bit car command into a modulated IR packet on IR_LED:
//  start burst, car-select burst, then right/left/backward/forward bursts, each followed by a silent gap.
//  Sits directly downstream of the IR transmitter bus interface and its rate/car-select logic.
//  That logic pulses SEND with the latched command and car-specific burst timings; this block drives the LED.
// PARAMETERS
//  CLK_FREQ_HZ      100_000_000  system clock frequency
//  CARRIER_FREQ_HZ  36_000       IR carrier frequency
//  START_BURST      191          carrier periods in start burst
//  SELECT_BURST     47           carrier periods in car-select burst
//  GAP_SIZE         25           carrier periods of silence after every burst
//  ASSERT_BURST     47           carrier periods for a command bit = 1
//  DEASSERT_BURST   22           carrier periods for a command bit = 0
// PORTS
//  CLK      in   1  system clock, rising edge
//  RESET    in   1  asynchronous, active-high
//  SEND     in   1  request packet; sampled every rising edge
//  COMMAND  in   4  {FORWARD, BACKWARD, LEFT, RIGHT}; sampled with SEND
//  BUSY     out  1  packet in progress
//  DONE     out  1  one-cycle pulse at packet end
//  IR_LED   out  1  modulated carrier output
// BEHAVIOUR
//  - Reset: async assert forces IDLE; IR_LED=0, BUSY=0, DONE=0, all counters and latched command cleared.
//  - Reset mid-packet aborts it; there is no resume. After deassert the block waits in IDLE for a new SEND.
//  - HALF = CLK_FREQ_HZ/(2*CARRIER_FREQ_HZ), integer-truncated; one carrier period = 2*HALF clocks.
//  - Accept: SEND=1 in IDLE at edge k.
//    * COMMAND is latched; BUSY=1 and state=START from cycle k+1.
//    * IR_LED=1 in cycle k+1, i.e. latency 1 clock.
//  - SEND while BUSY=1 is ignored. COMMAND changes after accept do not affect the packet in flight.
//  - FSM states and order:
//      IDLE->START->GAP->SELECT->GAP->RIGHT->GAP->LEFT->GAP->BACK->GAP->FWD->GAP->IDLE
//    * GAP returns to the next burst state via a segment index register.
//  - Burst length:
//    * START uses START_BURST; SELECT uses SELECT_BURST.
//    * RIGHT/LEFT/BACK/FWD use ASSERT_BURST if their latched bit is 1, else DEASSERT_BURST.
//  - Inside a burst:
//    * IR_LED=1 for HALF clocks, then 0 for HALF clocks, repeated for N periods.
//    * The carrier phase counter restarts at every segment entry, so each burst begins high.
//  - GAP holds IR_LED=0 for GAP_SIZE*2*HALF clocks.
//  - Segment counters: period counter width $clog2(max burst/gap + 1); phase counter width $clog2(HALF).
//    * Counters stop, never wrap, at terminal count.
//  - End of packet:
//    * On the last cycle of the final GAP the FSM moves to IDLE.
//    * In the following cycle DONE=1 for exactly one cycle and BUSY=0.
//    * SEND=1 in that same cycle is accepted, so back-to-back packets are allowed.
//  - Total clocks = 2*HALF*(START+SELECT+sum(bit bursts)+6*GAP_SIZE).
//  - IR_LED, BUSY and DONE are registered outputs, glitch-free.
// TESTING (bench params: CLK_FREQ_HZ=1000, CARRIER_FREQ_HZ=100 -> HALF=5; START=4, SELECT=3, GAP=2,
//          ASSERT=3, DEASSERT=1)
//  1 Reset -> IR_LED=0, BUSY=0, DONE=0; SEND held low 100 cycles -> IR_LED stays 0.
//  2 SEND pulse, COMMAND=4'b1010 -> BUSY high next cycle.
//    * IR_LED edge counts per segment: 4,3,1,3,1,3 rising edges.
//    * 270 cycles total; BUSY falls with a single-cycle DONE.
//  3 COMMAND=4'b0000 -> 4,3,1,1,1,1 bursts; 230 cycles.
//    COMMAND=4'b1111 -> 4,3,3,3,3,3 bursts; 310 cycles.
//  4 SEND re-pulsed and COMMAND changed mid-packet -> packet unchanged, no restart.
//    SEND in DONE cycle -> second packet starts next cycle.
//  5 Async RESET asserted mid-LEFT burst, between clock edges -> IR_LED=0 and BUSY=0 immediately.
//    DONE never pulses; next SEND starts a clean packet.
//  6 Check every burst starts with a HIGH half-period of exactly 5 cycles.
//    Check gaps are 20 cycles of IR_LED=0.

Source files
------------

// File: rtl/ir_packet_encoder.sv
// ---------------------------------------------------------------------------
// ir_packet_encoder
// Serialises one latched 4-bit car command into a modulated IR packet:
// START burst, car-select burst, then RIGHT/LEFT/BACK/FWD bursts, each
// followed by a silent gap. Burst lengths are in carrier periods; a carrier
// period is 2*HALF clocks (HALF clocks high, HALF clocks low).
//
// Ports
//   i_clk      system clock, rising edge
//   i_reset    asynchronous, active-high reset
//   i_send     packet request, sampled every rising edge (ignored while busy)
//   i_command  {FORWARD, BACKWARD, LEFT, RIGHT}, sampled with i_send
//   o_busy     packet in progress
//   o_done     one-cycle pulse after the final gap
//   o_ir_led   modulated carrier output
// ---------------------------------------------------------------------------
module ir_packet_encoder #(
   parameter int CLK_FREQ_HZ     = 100_000_000,
   parameter int CARRIER_FREQ_HZ = 36_000,
   parameter int START_BURST     = 191,
   parameter int SELECT_BURST    = 47,
   parameter int GAP_SIZE        = 25,
   parameter int ASSERT_BURST    = 47,
   parameter int DEASSERT_BURST  = 22
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_send,
   input  logic [3:0] i_command,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_ir_led
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int HALF   = CLK_FREQ_HZ / (2 * CARRIER_FREQ_HZ);
   localparam int MAXLEN = max2(max2(max2(START_BURST, SELECT_BURST), GAP_SIZE),
                                max2(ASSERT_BURST, DEASSERT_BURST));
   localparam int W_PER  = $clog2(MAXLEN + 1);
   localparam int W_PH   = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_GAP    = 3'd2,
      S_SELECT = 3'd3,
      S_RIGHT  = 3'd4,
      S_LEFT   = 3'd5,
      S_BACK   = 3'd6,
      S_FWD    = 3'd7
   } state_t;

   state_t             r_state;
   logic [3:0]         r_cmd;
   logic [2:0]         r_seg;      // index of the burst that precedes the current gap
   logic [W_PH-1:0]    r_phase;    // clocks elapsed inside the current half period
   logic               r_half;     // 0 = high half, 1 = low half of the carrier
   logic [W_PER-1:0]   r_period;   // carrier periods completed in this segment
   logic               r_busy;
   logic               r_done;
   logic               r_led;

   logic [W_PER-1:0]   w_len;
   state_t             w_next_burst;
   logic               w_end_half;
   logic               w_end_per;
   logic               w_end_seg;

   function automatic logic [W_PER-1:0] bit_len(input logic b);
      return b ? W_PER'(ASSERT_BURST) : W_PER'(DEASSERT_BURST);
   endfunction

   // Segment length (in carrier periods) of the current state
   always_comb begin
      w_len = W_PER'(1);
      case (r_state)
         S_START:  w_len = W_PER'(START_BURST);
         S_SELECT: w_len = W_PER'(SELECT_BURST);
         S_GAP:    w_len = W_PER'(GAP_SIZE);
         S_RIGHT:  w_len = bit_len(r_cmd[0]);
         S_LEFT:   w_len = bit_len(r_cmd[1]);
         S_BACK:   w_len = bit_len(r_cmd[2]);
         S_FWD:    w_len = bit_len(r_cmd[3]);
         default:  w_len = W_PER'(1);
      endcase
   end

   // Burst that follows the current gap, selected by the segment index
   always_comb begin
      w_next_burst = S_IDLE;
      case (r_seg)
         3'd0:    w_next_burst = S_SELECT;
         3'd1:    w_next_burst = S_RIGHT;
         3'd2:    w_next_burst = S_LEFT;
         3'd3:    w_next_burst = S_BACK;
         3'd4:    w_next_burst = S_FWD;
         default: w_next_burst = S_IDLE;
      endcase
   end

   assign w_end_half = (r_phase == W_PH'(HALF - 1));
   assign w_end_per  = w_end_half && r_half;
   assign w_end_seg  = w_end_per && (r_period == (w_len - W_PER'(1)));

   // Packet FSM with carrier/segment counters and registered outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_cmd    <= 4'd0;
         r_seg    <= 3'd0;
         r_phase  <= '0;
         r_half   <= 1'b0;
         r_period <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_led    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_led <= 1'b0;
               if (i_send) begin
                  r_cmd    <= i_command;
                  r_state  <= S_START;
                  r_seg    <= 3'd0;
                  r_phase  <= '0;
                  r_half   <= 1'b0;
                  r_period <= '0;
                  r_busy   <= 1'b1;
                  r_led    <= 1'b1;   // every burst begins with its high half
               end else begin
                  r_busy   <= 1'b0;
               end
            end
            S_GAP: begin
               if (w_end_seg) begin
                  r_phase  <= '0;
                  r_half   <= 1'b0;
                  r_period <= '0;
                  if (r_seg == 3'd5) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_led   <= 1'b0;
                  end else begin
                     r_state <= w_next_burst;
                     r_seg   <= r_seg + 3'd1;
                     r_led   <= 1'b1;
                  end
               end else begin
                  r_led <= 1'b0;
                  if (w_end_half) begin
                     r_phase <= '0;
                     r_half  <= ~r_half;
                     if (w_end_per) begin
                        r_period <= r_period + W_PER'(1);
                     end else begin
                        r_period <= r_period;
                     end
                  end else begin
                     r_phase <= r_phase + W_PH'(1);
                  end
               end
            end
            default: begin
               // Any burst state: START, SELECT, RIGHT, LEFT, BACK, FWD
               if (w_end_seg) begin
                  r_state  <= S_GAP;
                  r_phase  <= '0;
                  r_half   <= 1'b0;
                  r_period <= '0;
                  r_led    <= 1'b0;
               end else if (w_end_half) begin
                  r_phase <= '0;
                  r_half  <= ~r_half;
                  r_led   <= r_half;      // LED mirrors the new half: high when entering half 0
                  if (w_end_per) begin
                     r_period <= r_period + W_PER'(1);
                  end else begin
                     r_period <= r_period;
                  end
               end else begin
                  r_phase <= r_phase + W_PH'(1);
                  r_led   <= ~r_half;
               end
            end
         endcase
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_ir_led = r_led;

endmodule

// File: tb/tb_ir_packet_encoder.sv
// Self-checking bench for ir_packet_encoder with a small carrier (HALF = 5).
module tb_ir_packet_encoder;

   localparam int HALF_T   = 5;
   localparam int START_T  = 4;
   localparam int SELECT_T = 3;
   localparam int GAP_T    = 2;
   localparam int ASSERT_T = 3;
   localparam int DEASS_T  = 1;

   logic       clk;
   logic       rst;
   logic       send;
   logic [3:0] command;
   logic       busy;
   logic       done;
   logic       led;

   int n_tests = 0;
   int n_fail  = 0;
   bit exp_q[$];

   ir_packet_encoder #(
      .CLK_FREQ_HZ     (1000),
      .CARRIER_FREQ_HZ (100),
      .START_BURST     (START_T),
      .SELECT_BURST    (SELECT_T),
      .GAP_SIZE        (GAP_T),
      .ASSERT_BURST    (ASSERT_T),
      .DEASSERT_BURST  (DEASS_T)
   ) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_send    (send),
      .i_command (command),
      .o_busy    (busy),
      .o_done    (done),
      .o_ir_led  (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Expected LED waveform: per segment, N periods of HALF ones then HALF zeros, each
   // burst followed by GAP_T periods of zeros.
   function automatic void build_model(input logic [3:0] cmd);
      int seg[6];
      exp_q.delete();
      seg[0] = START_T;
      seg[1] = SELECT_T;
      for (int b = 0; b < 4; b++) seg[b+2] = cmd[b] ? ASSERT_T : DEASS_T;
      for (int s = 0; s < 6; s++) begin
         for (int p = 0; p < seg[s]; p++) begin
            for (int c = 0; c < HALF_T; c++) exp_q.push_back(1'b1);
            for (int c = 0; c < HALF_T; c++) exp_q.push_back(1'b0);
         end
         for (int c = 0; c < 2*HALF_T*GAP_T; c++) exp_q.push_back(1'b0);
      end
   endfunction

   // Runs one packet, sampling on falling edges; returns at the falling edge where busy is low.
   task automatic run_pkt(input logic [3:0] cmd, input bit pre_sent, input bit midchange,
                          output int ncyc, output int nrise, output int werr, output int first_busy);
      bit prev;
      build_model(cmd);
      if (!pre_sent) begin
         @(negedge clk);
         send = 1'b1;
         command = cmd;
      end
      @(negedge clk);
      send = 1'b0;
      first_busy = int'(busy);
      ncyc = 0; nrise = 0; werr = 0; prev = 1'b0;
      while (busy && ncyc < 1000) begin
         if (ncyc >= exp_q.size() || led !== exp_q[ncyc]) werr++;
         if (led && !prev) nrise++;
         prev = led;
         if (midchange && ncyc == 50) begin send = 1'b1; command = ~cmd; end
         if (midchange && ncyc == 52) send = 1'b0;
         ncyc++;
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [3:0] cmd;
      int         cycles;
      int         rises;
   } vec_t;

   initial begin
      vec_t vecs[5];
      int ncyc, nrise, werr, fb, cnt;
      logic [3:0] rc;

      vecs[0] = '{4'b1010, 270, 15};
      vecs[1] = '{4'b0000, 230, 11};
      vecs[2] = '{4'b1111, 310, 19};
      vecs[3] = '{4'b0101, 270, 15};
      vecs[4] = '{4'b0001, 250, 13};

      send = 1'b0; command = 4'd0; rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_led", int'(led), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      rst = 1'b0;

      // Idle with SEND low: LED must never rise
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (led || busy || done) cnt++;
      end
      check("idle_quiet", cnt, 0);

      // Table-driven packets
      foreach (vecs[i]) begin
         run_pkt(vecs[i].cmd, 1'b0, 1'b0, ncyc, nrise, werr, fb);
         check($sformatf("busy_start_%b", vecs[i].cmd), fb, 1);
         check($sformatf("cycles_%b", vecs[i].cmd), ncyc, vecs[i].cycles);
         check($sformatf("rises_%b", vecs[i].cmd), nrise, vecs[i].rises);
         check($sformatf("wave_%b", vecs[i].cmd), werr, 0);
         check($sformatf("done_%b", vecs[i].cmd), int'(done), 1);
         @(negedge clk);
         check($sformatf("done_1cyc_%b", vecs[i].cmd), int'(done), 0);
      end

      // SEND re-pulsed and COMMAND changed mid-packet
      run_pkt(4'b1010, 1'b0, 1'b1, ncyc, nrise, werr, fb);
      check("mid_cycles", ncyc, 270);
      check("mid_wave", werr, 0);
      check("mid_done", int'(done), 1);
      // Back-to-back: SEND in the DONE cycle
      send = 1'b1;
      command = 4'b0110;
      run_pkt(4'b0110, 1'b1, 1'b0, ncyc, nrise, werr, fb);
      check("b2b_busy_next", fb, 1);
      check("b2b_cycles", ncyc, 270);
      check("b2b_wave", werr, 0);
      check("b2b_done", int'(done), 1);
      @(negedge clk);
      check("b2b_idle", int'(busy), 0);

      // Async reset mid-LEFT burst (LEFT starts at sample 140 for 4'b1010)
      @(negedge clk);
      send = 1'b1; command = 4'b1010;
      @(negedge clk);
      send = 1'b0;
      repeat (143) @(negedge clk);
      check("pre_reset_led", int'(led), 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_led", int'(led), 0);
      check("arst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done || busy || led) cnt++;
      end
      check("arst_no_done", cnt, 0);
      run_pkt(4'b1010, 1'b0, 1'b0, ncyc, nrise, werr, fb);
      check("post_rst_cycles", ncyc, 270);
      check("post_rst_wave", werr, 0);

      // Randomized packets against the model
      for (int r = 0; r < 8; r++) begin
         rc = 4'($urandom_range(0, 15));
         run_pkt(rc, 1'b0, 1'b0, ncyc, nrise, werr, fb);
         check($sformatf("rnd_len_%b", rc), ncyc, exp_q.size());
         check($sformatf("rnd_wave_%b", rc), werr, 0);
         check($sformatf("rnd_done_%b", rc), int'(done), 1);
         repeat ($urandom_range(1, 4)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
